count_snap_fifo: RTL and testbench

COUNT_SNAP_FIFO -- requirements
Module: count_snap_fifo

---
 rtl/count_snap_fifo.sv | 124 ++++++++++++
 tb/tb_count_snap_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_snap_fifo.sv
`default_nettype none
// ============================================================================
// Module      : count_snap_fifo
// Description : First-word fall-through FIFO that captures snapshots of an
//               upstream counter. A sticky flag records dropped captures.
//               Defining COUNT_SNAP_WRAP_EN adds a 4-bit wrap counter, placed
//               in the top bits of each entry.
// Revision    : 1.0 - initial release
// ============================================================================
module count_snap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_gate,
    input  logic                     resetn,
    input  logic [WIDTH-1:0]         i_count,
    input  logic                     i_count_end,
    input  logic                     i_capture,
    input  logic                     i_snap_ready,
    input  logic                     i_ovf_clr,
    output logic                     o_snap_valid,
    output logic [WIDTH+3:0]         o_snap_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);

    localparam int              c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full = (c_aw+1)'(DEPTH);
    localparam logic [c_aw:0]   c_one  = (c_aw+1)'(1);

    logic [WIDTH+3:0] mem_q [DEPTH];
    logic [WIDTH+3:0] mem_d [DEPTH];
    logic [c_aw:0]    wr_ptr_q, wr_ptr_d;
    logic [c_aw:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;

    logic [c_aw:0]    w_level;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [3:0]       w_wrap;

`ifdef COUNT_SNAP_WRAP_EN
    logic       count_end_q, count_end_d;
    logic [3:0] wrap_q, wrap_d;

    // Entries take wrap_q, so a capture on a rising edge sees the old value.
    always_comb begin
        count_end_d = i_count_end;
        wrap_d      = wrap_q;
        if (i_count_end && !count_end_q) begin
            wrap_d = wrap_q + 4'd1;
        end
    end

    always_ff @(posedge clk_gate or negedge resetn) begin
        if (!resetn) begin
            count_end_q <= 1'b0;
            wrap_q      <= 4'd0;
        end else begin
            count_end_q <= count_end_d;
            wrap_q      <= wrap_d;
        end
    end

    assign w_wrap = wrap_q;
`else
    logic w_unused_count_end;

    assign w_unused_count_end = i_count_end;
    assign w_wrap             = 4'd0;
`endif

    // Pointers carry one extra bit so full and empty differ in the MSB.
    assign w_level = wr_ptr_q - rd_ptr_q;
    assign w_full  = (w_level == c_full);
    assign w_pop   = (w_level != '0) && i_snap_ready;
    assign w_push  = i_capture && (!w_full || w_pop);
    assign w_drop  = i_capture && w_full && !w_pop;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (w_push) begin
            mem_d[wr_ptr_q[c_aw-1:0]] = {w_wrap, i_count};
            wr_ptr_d                  = wr_ptr_q + c_one;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_one;
        end
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (i_ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_gate or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the output is masked whenever the FIFO is empty.
    always_ff @(posedge clk_gate) begin
        mem_q <= mem_d;
    end

    assign o_snap_valid = (w_level != '0);
    assign o_snap_data  = o_snap_valid ? mem_q[rd_ptr_q[c_aw-1:0]] : '0;
    assign o_level      = w_level;
    assign o_overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_count_snap_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_snap_fifo
// Description : Self-checking bench for count_snap_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_snap_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef COUNT_SNAP_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic             clk_gate = 1'b0;
    logic             resetn;
    logic [WIDTH-1:0] count;
    logic             count_end;
    logic             capture;
    logic             snap_ready;
    logic             ovf_clr;
    logic             snap_valid;
    logic [WIDTH+3:0] snap_data;
    logic [2:0]       level;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH+3:0] mq[$];
    int               m_wrap;
    bit               m_prev_end;
    bit               m_ovf;

    count_snap_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_gate     (clk_gate),
        .resetn       (resetn),
        .i_count      (count),
        .i_count_end  (count_end),
        .i_capture    (capture),
        .i_snap_ready (snap_ready),
        .i_ovf_clr    (ovf_clr),
        .o_snap_valid (snap_valid),
        .o_snap_data  (snap_data),
        .o_level      (level),
        .o_overflow   (overflow)
    );

    always #5 clk_gate = ~clk_gate;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_wrap     = 0;
        m_prev_end = 1'b0;
        m_ovf      = 1'b0;
    endtask

    task automatic model_update();
        int               sz;
        bit               full;
        bit               pop;
        logic [WIDTH+3:0] e;
        logic [WIDTH+3:0] discard;
        if (!resetn) begin
            model_reset();
            return;
        end
        sz   = mq.size();
        full = (sz == DEPTH);
        pop  = (sz > 0) && snap_ready;
        e    = {(WRAP_EN ? 4'(m_wrap) : 4'h0), count};
        if (pop) discard = mq.pop_front();
        if (capture && (!full || pop)) mq.push_back(e);
        if (capture && full && !pop) m_ovf = 1'b1;
        else if (ovf_clr)            m_ovf = 1'b0;
        if (count_end && !m_prev_end) m_wrap = (m_wrap + 1) % 16;
        m_prev_end = count_end;
    endtask

    task automatic compare();
        chk("valid", snap_valid, mq.size() != 0);
        chk("level", level, mq.size());
        chk("overflow", overflow, m_ovf);
        if (mq.size() > 0) chk("data", snap_data, mq[0]);
    endtask

    // One clock: model follows the edge, DUT is checked on the falling edge.
    task automatic tick();
        @(posedge clk_gate);
        model_update();
        @(negedge clk_gate);
        compare();
    endtask

    task automatic idle_inputs();
        capture    = 1'b0;
        snap_ready = 1'b0;
        ovf_clr    = 1'b0;
        count_end  = 1'b0;
        count      = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        do_reset();
        chk("rst_valid", snap_valid, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_data", snap_data, 12'h000);

        // Single capture into an empty FIFO
        capture = 1'b1; count = 8'h05;
        tick();
        capture = 1'b0;
        chk("cap1_valid", snap_valid, 1'b1);
        chk("cap1_data", snap_data, 12'h005);
        chk("cap1_level", level, 3'd1);

        // Five captures into a depth-4 FIFO, then ordered drain
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            capture = 1'b1; count = 8'(i);
            tick();
        end
        capture = 1'b0;
        chk("ovf5_level", level, 3'd4);
        chk("ovf5_flag", overflow, 1'b1);
        snap_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf5_pop", snap_data, 32'(i));
            tick();
        end
        snap_ready = 1'b0;
        chk("ovf5_empty", level, 3'd0);

        // Refill, then clear colliding with a new overflow
        for (int i = 0; i < 4; i++) begin
            capture = 1'b1; count = 8'(8'h21 + i);
            tick();
        end
        capture = 1'b1; ovf_clr = 1'b1; count = 8'h25;
        tick();
        chk("clr_race_ovf", overflow, 1'b1);
        chk("clr_race_level", level, 3'd4);
        capture = 1'b0;
        tick();
        ovf_clr = 1'b0;
        chk("clr_alone_ovf", overflow, 1'b0);

        // Full FIFO: capture with simultaneous pop
        capture = 1'b1; snap_ready = 1'b1; count = 8'hAA;
        tick();
        capture = 1'b0;
        chk("fullpp_level", level, 3'd4);
        chk("fullpp_ovf", overflow, 1'b0);
        tick(); tick(); tick();
        chk("fullpp_last", snap_data, 12'h0AA);
        chk("fullpp_lvl1", level, 3'd1);
        tick();
        snap_ready = 1'b0;

        // Two held count_end pulses, then a capture
        do_reset();
        repeat (2) begin
            count_end = 1'b1;
            tick(); tick(); tick();
            count_end = 1'b0;
            tick();
        end
        capture = 1'b1; count = 8'h10;
        tick();
        capture = 1'b0;
        chk("wrap_data", snap_data, WRAP_EN ? 12'h210 : 12'h010);

        // Asynchronous reset between edges with three entries stored
        do_reset();
        for (int i = 0; i < 3; i++) begin
            capture = 1'b1; count = 8'(8'h31 + i);
            tick();
        end
        capture = 1'b0;
        chk("arst_pre_level", level, 3'd3);
        #1 resetn = 1'b0;
        #1;
        chk("arst_valid", snap_valid, 1'b0);
        chk("arst_level", level, 3'd0);
        chk("arst_data", snap_data, 12'h000);
        model_reset();
        #1 resetn = 1'b1;
        capture = 1'b1; count = 8'h77;
        tick();
        capture = 1'b0;
        chk("arst_head", snap_data, 12'h077);
        chk("arst_lvl1", level, 3'd1);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            resetn     = ($urandom_range(0, 199) != 0);
            capture    = ($urandom_range(0, 9) < 6);
            snap_ready = ($urandom_range(0, 1) == 1);
            ovf_clr    = ($urandom_range(0, 9) == 0);
            count      = 8'($urandom);
            if ($urandom_range(0, 3) == 0) count_end = ~count_end;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
